// File: rtl/vco_band_cal_if.sv
`default_nettype none
// ============================================================================
// vco_band_cal_if : control/status bundle of the VCO coarse-band calibrator
// Revision 1.0
// ============================================================================
interface vco_band_cal_if;
   logic        start;
   logic [5:0]  cfs_in;
   logic [7:0]  n_int;
   logic [4:0]  alpha;
   logic        ref_tick;
   logic        fb_tick;
   logic [5:0]  band;
   logic        busy;
   logic        done;
   logic        fail;
   logic [12:0] meas_cnt;
   logic [13:0] err;

   modport master (
      output start, cfs_in, n_int, alpha, ref_tick, fb_tick,
      input  band, busy, done, fail, meas_cnt, err
   );

   modport slave (
      input  start, cfs_in, n_int, alpha, ref_tick, fb_tick,
      output band, busy, done, fail, meas_cnt, err
   );
endinterface
`default_nettype wire

// File: rtl/vco_band_cal.sv
`default_nettype none
// ============================================================================
// vco_band_cal : settle/measure/step search for the VCO coarse capacitor band
// Revision 1.0
// ============================================================================
module vco_band_cal #(
   parameter int SETTLE_CYC = 64,
   parameter int TOL        = 2,
   parameter int MAX_ITER   = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   vco_band_cal_if.slave  cal_if
);

   localparam int WIN_REF = 256;
   localparam int SW      = $clog2(SETTLE_CYC + 1);
   localparam int RW      = $clog2(WIN_REF + 1);
   localparam int IW      = $clog2(MAX_ITER + 1);

   localparam logic [13:0] TOL_V    = 14'(TOL);
   localparam logic [12:0] FB_MAX   = 13'h1FFF;
   localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYC - 1);
   localparam logic [RW-1:0] WIN_LAST = RW'(WIN_REF - 1);
   localparam logic [IW-1:0] ITER_LIM = IW'(MAX_ITER);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD    = 3'd1;
   localparam logic [2:0] S_SETTLE  = 3'd2;
   localparam logic [2:0] S_MEASURE = 3'd3;
   localparam logic [2:0] S_DECIDE  = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;
   localparam logic [2:0] S_FAIL    = 3'd6;

   logic [2:0]         state_q,    state_d;
   logic [5:0]         band_q,     band_d;
   logic               busy_q,     busy_d;
   logic               done_q,     done_d;
   logic               fail_q,     fail_d;
   logic [12:0]        meas_q,     meas_d;
   logic [13:0]        err_q,      err_d;
   logic [13:0]        target_q,   target_d;
   logic [SW-1:0]      settle_q,   settle_d;
   logic [RW-1:0]      ref_q,      ref_d;
   logic [12:0]        fb_q,       fb_d;
   logic [IW-1:0]      iter_q,     iter_d;
   logic [13:0]        prev_err_q, prev_err_d;
   logic               prev_up_q,  prev_up_d;
   logic               have_prev_q, have_prev_d;

   logic signed [14:0] w_err_wide;
   logic [13:0]        w_err;
   logic [13:0]        w_abs_err;
   logic [13:0]        w_abs_prev;
   logic               w_up;
   logic [5:0]         w_step_band;
   logic               w_at_edge;

   // Only a saturated count against a negative target can exceed +8191; clamp it.
   assign w_err_wide = $signed({2'b00, fb_q}) - $signed({target_q[13], target_q});
   assign w_err      = (!w_err_wide[14] && w_err_wide[13]) ? 14'h1FFF : w_err_wide[13:0];
   assign w_abs_err  = w_err[13] ? (14'd0 - w_err) : w_err;
   assign w_abs_prev = prev_err_q[13] ? (14'd0 - prev_err_q) : prev_err_q;
   assign w_up        = w_err[13];
   assign w_step_band = w_up ? (band_q + 6'd1) : (band_q - 6'd1);
   assign w_at_edge   = w_up ? (band_q == 6'd63) : (band_q == 6'd0);

   always_comb begin
      state_d     = state_q;
      band_d      = band_q;
      busy_d      = busy_q;
      done_d      = done_q;
      fail_d      = fail_q;
      meas_d      = meas_q;
      err_d       = err_q;
      target_d    = target_q;
      settle_d    = settle_q;
      ref_d       = ref_q;
      fb_d        = fb_q;
      iter_d      = iter_q;
      prev_err_d  = prev_err_q;
      prev_up_d   = prev_up_q;
      have_prev_d = have_prev_q;

      case (state_q)
         S_IDLE: begin
            if (cal_if.start) begin
               band_d      = cal_if.cfs_in;
               target_d    = {2'b00, cal_if.n_int, 4'b0000}
                           + {{9{cal_if.alpha[4]}}, cal_if.alpha};
               iter_d      = '0;
               done_d      = 1'b0;
               fail_d      = 1'b0;
               busy_d      = 1'b1;
               have_prev_d = 1'b0;
               state_d     = S_LOAD;
            end
         end
         S_LOAD: begin
            settle_d = '0;
            ref_d    = '0;
            fb_d     = '0;
            state_d  = S_SETTLE;
         end
         S_SETTLE: begin
            if (cal_if.ref_tick) begin
               if (settle_q == SET_LAST) begin
                  state_d = S_MEASURE;
               end else begin
                  settle_d = settle_q + 1'b1;
               end
            end
         end
         S_MEASURE: begin
            // A fb tick coinciding with the closing ref tick still lands in fb_q.
            if (cal_if.fb_tick && (fb_q != FB_MAX)) begin
               fb_d = fb_q + 13'd1;
            end
            if (cal_if.ref_tick) begin
               if (ref_q == WIN_LAST) begin
                  state_d = S_DECIDE;
               end else begin
                  ref_d = ref_q + 1'b1;
               end
            end
         end
         S_DECIDE: begin
            meas_d = fb_q;
            err_d  = w_err;
            if (w_abs_err <= TOL_V) begin
               state_d = S_DONE;
            end else if (have_prev_q && (w_up != prev_up_q)) begin
               // Reversal: stepping back lands on the earlier band, which wins ties.
               if (w_abs_prev <= w_abs_err) begin
                  band_d = w_step_band;
               end
               state_d = S_DONE;
            end else if (w_at_edge || (iter_q == ITER_LIM)) begin
               state_d = S_FAIL;
            end else begin
               band_d      = w_step_band;
               iter_d      = iter_q + 1'b1;
               prev_err_d  = w_err;
               prev_up_d   = w_up;
               have_prev_d = 1'b1;
               state_d     = S_LOAD;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         S_FAIL: begin
            busy_d  = 1'b0;
            fail_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         band_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fail_q      <= 1'b0;
         meas_q      <= '0;
         err_q       <= '0;
         target_q    <= '0;
         settle_q    <= '0;
         ref_q       <= '0;
         fb_q        <= '0;
         iter_q      <= '0;
         prev_err_q  <= '0;
         prev_up_q   <= 1'b0;
         have_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         band_q      <= band_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         fail_q      <= fail_d;
         meas_q      <= meas_d;
         err_q       <= err_d;
         target_q    <= target_d;
         settle_q    <= settle_d;
         ref_q       <= ref_d;
         fb_q        <= fb_d;
         iter_q      <= iter_d;
         prev_err_q  <= prev_err_d;
         prev_up_q   <= prev_up_d;
         have_prev_q <= have_prev_d;
      end
   end

   assign cal_if.band     = band_q;
   assign cal_if.busy     = busy_q;
   assign cal_if.done     = done_q;
   assign cal_if.fail     = fail_q;
   assign cal_if.meas_cnt = meas_q;
   assign cal_if.err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_vco_band_cal.sv
`default_nettype none
// ============================================================================
// tb_vco_band_cal : directed scoreboard bench with a per-band VCO rate model
// Revision 1.0
// ============================================================================
module tb_vco_band_cal;

   localparam int REF_DIV = 8;
   localparam int WIN_CYC = 256 * REF_DIV;
   localparam int ITER_CYC = 2560;
   localparam int LIMIT   = 30000;

   typedef struct {
      int band;
      int done;
      int fail;
      int meas;
      int err;
      int wins;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   rate_tbl [64];
   exp_t sb_q [$];

   vco_band_cal_if bus ();

   vco_band_cal dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .cal_if (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // VCO model: fractional accumulator gives exactly rate_tbl[band] fb ticks per window.
   initial begin
      int acc;
      int ph;
      acc = 0;
      ph  = 0;
      bus.ref_tick = 1'b0;
      bus.fb_tick  = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         ph = (ph + 1) % REF_DIV;
         bus.ref_tick = (ph == 0);
         acc += rate_tbl[bus.band];
         if (acc >= WIN_CYC) begin
            acc -= WIN_CYC;
            bus.fb_tick = 1'b1;
         end else begin
            bus.fb_tick = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic set_rates(input int dflt, input int b1, input int r1,
                            input int b2, input int r2);
      for (int i = 0; i < 64; i++) rate_tbl[i] = dflt;
      rate_tbl[b1] = r1;
      rate_tbl[b2] = r2;
   endtask

   task automatic run_cal(input int cfs, input int n, input int a,
                          input exp_t e, input bit poke);
      int   cyc;
      exp_t x;
      @(posedge clk);
      #1;
      bus.cfs_in = 6'(cfs);
      bus.n_int  = 8'(n);
      bus.alpha  = 5'(a);
      bus.start  = 1'b1;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("busy_set", bus.busy, 1);
      check("done_clr", bus.done, 0);
      check("fail_clr", bus.fail, 0);
      cyc = 1;
      while ((bus.busy === 1'b1) && (cyc < LIMIT)) begin
         @(posedge clk);
         #1;
         cyc++;
         if (poke && (cyc == 300)) begin
            bus.start  = 1'b1;
            bus.cfs_in = 6'd50;
            bus.n_int  = 8'd0;
         end
         if (poke && (cyc == 301)) bus.start = 1'b0;
      end
      check("busy_drop", bus.busy, 0);
      x = sb_q.pop_front();
      check("band", bus.band, x.band);
      check("done", bus.done, x.done);
      check("fail", bus.fail, x.fail);
      check("meas_cnt", bus.meas_cnt, x.meas);
      check("err", $signed(bus.err), x.err);
      check("windows", (cyc + ITER_CYC / 2) / ITER_CYC, x.wins);
      repeat (3) @(posedge clk);
      #1;
      check("flag_sticky", bus.done | bus.fail, 1);
      check("band_hold", bus.band, x.band);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.cfs_in = '0;
      bus.n_int  = '0;
      bus.alpha  = '0;
      set_rates(1064, 0, 1064, 0, 1064);

      repeat (3) @(negedge clk);
      check("rst_band", bus.band, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_fail", bus.fail, 0);
      check("rst_meas", bus.meas_cnt, 0);
      check("rst_err", bus.err, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);

      // Exact hit on the first band.
      set_rates(1064, 0, 1064, 0, 1064);
      run_cal(20, 66, 8, '{band: 20, done: 1, fail: 0, meas: 1064, err: 0, wins: 1}, 1'b0);

      // One step up; a start and new inputs mid-run must be ignored.
      set_rates(1050, 20, 1050, 21, 1063);
      run_cal(20, 66, 8, '{band: 21, done: 1, fail: 0, meas: 1063, err: -1, wins: 2}, 1'b1);

      // Reversal with equal |err|: the earlier band is kept.
      set_rates(1070, 30, 1070, 29, 1058);
      run_cal(30, 66, 8, '{band: 30, done: 1, fail: 0, meas: 1058, err: -6, wins: 2}, 1'b0);

      // Negative alpha (target 1008) with error exactly at +TOL.
      set_rates(1010, 5, 1010, 5, 1010);
      run_cal(5, 64, -16, '{band: 5, done: 1, fail: 0, meas: 1010, err: 2, wins: 1}, 1'b0);

      // Upward step required from the top band.
      set_rates(1050, 63, 1050, 63, 1050);
      run_cal(63, 66, 8, '{band: 63, done: 0, fail: 1, meas: 1050, err: -14, wins: 1}, 1'b0);

      // Downward step required from band 0, error just outside TOL.
      set_rates(1067, 0, 1067, 0, 1067);
      run_cal(0, 66, 8, '{band: 0, done: 0, fail: 1, meas: 1067, err: 3, wins: 1}, 1'b0);

      // Monotonic approach never reaching TOL exhausts the iteration budget.
      for (int b = 0; b < 64; b++) rate_tbl[b] = 1000 + b;
      run_cal(10, 66, 8, '{band: 18, done: 0, fail: 1, meas: 1018, err: -46, wins: 9}, 1'b0);

      // Asynchronous reset during MEASURE aborts without flags.
      set_rates(1064, 0, 1064, 0, 1064);
      @(posedge clk);
      #1;
      bus.cfs_in = 6'd20;
      bus.n_int  = 8'd66;
      bus.alpha  = 5'd8;
      bus.start  = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (1500) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_band", bus.band, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      check("abort_fail", bus.fail, 0);
      check("abort_meas", bus.meas_cnt, 0);
      check("abort_err", bus.err, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("idle_busy", bus.busy, 0);
      check("idle_flags", bus.done | bus.fail, 0);
      run_cal(20, 66, 8, '{band: 20, done: 1, fail: 0, meas: 1064, err: 0, wins: 1}, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
